// File: rtl/lb_if.sv
// XT local-bus request bundle: the fabric drives it, peripherals decode it.
interface lb_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  modport master (output wr, rd, addr, wdata);
  modport slave  (input  wr, rd, addr, wdata);
endinterface

// File: rtl/led_seq_ctrl.sv
// Local-bus LED sequencer: direct drive in IDLE, or steps through a pattern table
// (looping or one-shot) at a programmable step period. LEDs are active-low.
module led_seq_ctrl #(
  parameter int unsigned LED_NUM   = 8,
  parameter int unsigned STEPS     = 16,
  parameter int unsigned PRESC_W   = 24,
  parameter logic [7:0]  BASE_ADDR = 8'd24
) (
  input  logic               lb_clk,
  input  logic               rst_n,
  lb_if.slave                xt_lb,
  output logic [31:0]        rdata,
  output logic [LED_NUM-1:0] led
);

  localparam int unsigned SW = $clog2(STEPS);

  localparam logic [7:0] A_CTRL    = BASE_ADDR;
  localparam logic [7:0] A_PERIOD  = BASE_ADDR + 8'd1;
  localparam logic [7:0] A_PATTERN = BASE_ADDR + 8'd2;
  localparam logic [7:0] A_DIRECT  = BASE_ADDR + 8'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        step_q, step_d;
  logic [SW-1:0]        last_q, last_d;
  logic [SW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PRESC_W-1:0]   period_q, period_d;
  logic [LED_NUM-1:0]   direct_q, direct_d;
  logic [LED_NUM-1:0]   led_d;
  logic                 run_q, run_d;
  logic                 loop_q, loop_d;

  logic [LED_NUM-1:0]   tbl [STEPS];

  logic wr_ctrl, wr_period, wr_pattern, wr_direct;
  logic rd_ctrl, rd_period, rd_direct;
  logic unused_wdata;

  // Address decode for writes and reads
  assign wr_ctrl    = xt_lb.wr && (xt_lb.addr == A_CTRL);
  assign wr_period  = xt_lb.wr && (xt_lb.addr == A_PERIOD);
  assign wr_pattern = xt_lb.wr && (xt_lb.addr == A_PATTERN);
  assign wr_direct  = xt_lb.wr && (xt_lb.addr == A_DIRECT);
  assign rd_ctrl    = xt_lb.rd && (xt_lb.addr == A_CTRL);
  assign rd_period  = xt_lb.rd && (xt_lb.addr == A_PERIOD);
  assign rd_direct  = xt_lb.rd && (xt_lb.addr == A_DIRECT);

  // Only some write-data bits are meaningful to this slave
  assign unused_wdata = ^xt_lb.wdata;

  // Pattern table storage; deliberately not reset
  always_ff @(posedge lb_clk) begin
    if (wr_pattern) tbl[wr_ptr_q] <= xt_lb.wdata[LED_NUM-1:0];
  end

  // Next-state, register-write and LED-select logic
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    presc_d  = presc_q;
    period_d = period_q;
    direct_d = direct_q;
    run_d    = run_q;
    loop_d   = loop_q;
    led_d    = direct_q;

    if (wr_period) period_d = xt_lb.wdata[PRESC_W-1:0];
    if (wr_direct) direct_d = xt_lb.wdata[LED_NUM-1:0];
    if (wr_pattern) wr_ptr_d = wr_ptr_q + SW'(1);
    // Clear lands after the pattern write has used the old pointer
    if (wr_ctrl && xt_lb.wdata[2]) wr_ptr_d = '0;

    case (state_q)
      IDLE:    led_d = direct_q;
      RUN:     led_d = tbl[step_q];
      HOLD:    led_d = tbl[last_q];
      default: led_d = '1;
    endcase

    // A CTRL write pre-empts any step tick in the same cycle
    if (wr_ctrl) begin
      run_d  = xt_lb.wdata[0];
      loop_d = xt_lb.wdata[1];
      last_d = xt_lb.wdata[4 +: SW];
      if (xt_lb.wdata[0]) begin
        state_d = RUN;
        step_d  = '0;
        presc_d = period_q;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == RUN) begin
      if (presc_q == '0) begin
        presc_d = period_q;
        if (step_q != last_q) begin
          step_d = step_q + SW'(1);
        end else if (loop_q) begin
          step_d = '0;
        end else begin
          state_d = HOLD;
          run_d   = 1'b0;
        end
      end else begin
        presc_d = presc_q - PRESC_W'(1);
      end
    end
  end

  // Control and LED registers
  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      presc_q  <= '0;
      period_q <= '0;
      direct_q <= '1;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      led      <= '1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      direct_q <= direct_d;
      run_q    <= run_d;
      loop_q   <= loop_d;
      led      <= led_d;
    end
  end

  // Read mux; zero when not addressed so the fabric can OR slaves together
  always_comb begin
    rdata = '0;
    if (rd_ctrl) begin
      rdata[17:16]     = state_q;
      rdata[12 +: SW]  = step_q;
      rdata[8 +: SW]   = wr_ptr_q;
      rdata[4 +: SW]   = last_q;
      rdata[1]         = loop_q;
      rdata[0]         = run_q;
    end else if (rd_period) begin
      rdata = 32'(period_q);
    end else if (rd_direct) begin
      rdata = 32'(direct_q);
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized self-checking bench for led_seq_ctrl with a sequence-level LED model.
module tb_led_seq_ctrl;
  localparam int unsigned LED_NUM = 8;
  localparam int unsigned STEPS   = 16;
  localparam logic [7:0]  BASE    = 8'd24;
  localparam logic [7:0]  A_CTRL  = BASE;
  localparam logic [7:0]  A_PER   = BASE + 8'd1;
  localparam logic [7:0]  A_PAT   = BASE + 8'd2;
  localparam logic [7:0]  A_DIR   = BASE + 8'd3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        rdata;
  logic [LED_NUM-1:0] led;

  lb_if bus ();

  led_seq_ctrl #(
    .LED_NUM(LED_NUM), .STEPS(STEPS), .PRESC_W(24), .BASE_ADDR(BASE)
  ) dut (
    .lb_clk(clk), .rst_n(rst_n), .xt_lb(bus), .rdata(rdata), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl_m [STEPS];
  logic [7:0] direct_m;
  int         cur_last;
  int         cur_p;
  int         wp_m;

  // Expected LED for the k-th displayed cycle after a run start
  function automatic logic [7:0] exp_led(input int k, input int last, input int p, input bit loop);
    int idx;
    idx = k / (p + 1);
    if (loop) idx = idx % (last + 1);
    else if (idx > last) idx = last;
    return tbl_m[idx];
  endfunction

  // Caller is at a negedge; write is sampled at the next posedge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0; bus.wdata = '0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.rd = 1'b1; bus.addr = a;
    #1 d = rdata;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic load_patterns(input int n, input bit directed);
    bus_write(A_CTRL, 32'h4);
    wp_m = 0;
    for (int i = 0; i < n; i++) begin
      tbl_m[i] = directed ? 8'(1 << i) : 8'($urandom);
      bus_write(A_PAT, {24'h0, tbl_m[i]});
      wp_m = (wp_m + 1) % STEPS;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.wdata = '0;
    #12;
    checks++;
    if (led !== 8'hFF) begin errors++; $display("FAIL reset_led got %h exp ff", led); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_idle got %h exp 0", rdata); end
    bus.rd = 1'b1; bus.addr = A_CTRL;
    #1 d = rdata;
    bus.rd = 1'b0;
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl_read got %h exp 0", d); end
    @(negedge clk);
    rst_n = 1'b1;
    direct_m = 8'hFF;
    @(negedge clk);
  endtask

  task automatic test_direct();
    logic [31:0] d;
    logic [7:0]  v;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 8'hA5 : 8'($urandom);
      bus_write(A_DIR, {$urandom, v} >> 0 & 32'hFFFF_FF00 | {24'h0, v});
      direct_m = v;
      @(negedge clk);
      checks++;
      if (led !== v) begin errors++; $display("FAIL direct_led[%0d] got %h exp %h", i, led, v); end
      bus_read(A_DIR, d);
      checks++;
      if (d !== {24'h0, v}) begin errors++; $display("FAIL direct_read[%0d] got %h exp %h", i, d, v); end
    end
    bus_read(A_PAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL pattern_read got %h exp 0", d); end
    bus_read(BASE + 8'd4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", d); end
  endtask

  task automatic test_oneshot(input int n, input int p, input bit directed);
    logic [31:0] d;
    logic [31:0] exp;
    int          bad;
    load_patterns(n, directed);
    bus_write(A_PER, 32'(p));
    cur_last = n - 1;
    cur_p    = p;
    bus_write(A_CTRL, 32'((cur_last << 4) | 1));
    bad = 0;
    for (int k = 0; k < (cur_last + 1) * (p + 1) + 4; k++) begin
      @(negedge clk);
      checks++;
      if (led !== exp_led(k, cur_last, p, 1'b0)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL oneshot_led n=%0d p=%0d k=%0d got %h exp %h",
                              n, p, k, led, exp_led(k, cur_last, p, 1'b0));
      end
    end
    bus_read(A_CTRL, d);
    exp = (32'd2 << 16) | 32'(cur_last << 12) | 32'(wp_m << 8) | 32'(cur_last << 4);
    checks++;
    if (d !== exp) begin errors++; $display("FAIL oneshot_ctrl got %h exp %h", d, exp); end
  endtask

  task automatic test_hold_restart();
    int bad;
    checks++;
    if (led !== tbl_m[cur_last]) begin
      errors++; $display("FAIL hold_led got %h exp %h", led, tbl_m[cur_last]);
    end
    bus_write(A_CTRL, 32'((cur_last << 4) | 1));
    bad = 0;
    for (int k = 0; k < (cur_last + 1) * (cur_p + 1) + 2; k++) begin
      @(negedge clk);
      checks++;
      if (led !== exp_led(k, cur_last, cur_p, 1'b0)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL restart_led k=%0d got %h exp %h", k, led,
                              exp_led(k, cur_last, cur_p, 1'b0));
      end
    end
    bus_write(A_CTRL, 32'h0);
    @(negedge clk);
    checks++;
    if (led !== direct_m) begin errors++; $display("FAIL hold_to_idle got %h exp %h", led, direct_m); end
  endtask

  task automatic test_loop_wrap(input int p);
    logic [31:0] d;
    int          bad;
    load_patterns(STEPS, 1'b0);
    bus_read(A_CTRL, d);
    checks++;
    if (d[11:8] !== 4'h0) begin errors++; $display("FAIL wrptr_wrap got %h exp 0", d[11:8]); end
    bus_write(A_PER, 32'(p));
    bus_read(A_PER, d);
    checks++;
    if (d !== 32'(p)) begin errors++; $display("FAIL period_read got %h exp %h", d, p); end
    bus_write(A_CTRL, 32'(((STEPS - 1) << 4) | 3));
    bad = 0;
    for (int k = 0; k < 2 * STEPS * (p + 1) + 5; k++) begin
      @(negedge clk);
      checks++;
      if (led !== exp_led(k, STEPS - 1, p, 1'b1)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL loop_led p=%0d k=%0d got %h exp %h", p, k, led,
                              exp_led(k, STEPS - 1, p, 1'b1));
      end
    end
  endtask

  // Abort exactly on a tick cycle; the abort must win and the step must not advance
  task automatic test_abort(input int p, input int m);
    logic [31:0] d;
    logic [31:0] exp;
    int          j;
    j = (p + 1) * m;
    bus_write(A_CTRL, 32'(((STEPS - 1) << 4) | 3));
    for (int k = 0; k < j - 1; k++) begin
      @(negedge clk);
      checks++;
      if (led !== exp_led(k, STEPS - 1, p, 1'b1)) begin
        errors++; $display("FAIL abort_pre k=%0d got %h exp %h", k, led, exp_led(k, STEPS - 1, p, 1'b1));
      end
    end
    bus_write(A_CTRL, 32'(((STEPS - 1) << 4) | 2));
    checks++;
    if (led !== tbl_m[m - 1]) begin errors++; $display("FAIL abort_edge got %h exp %h", led, tbl_m[m - 1]); end
    @(negedge clk);
    checks++;
    if (led !== direct_m) begin errors++; $display("FAIL abort_led got %h exp %h", led, direct_m); end
    bus_read(A_CTRL, d);
    exp = 32'((m - 1) << 12) | 32'((STEPS - 1) << 4) | 32'h2;
    checks++;
    if (d !== exp) begin errors++; $display("FAIL abort_ctrl got %h exp %h", d, exp); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bus_write(A_CTRL, 32'(((STEPS - 1) << 4) | 3));
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'hFF) begin errors++; $display("FAIL async_reset_led got %h exp ff", led); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_reset_ctrl got %h exp 0", d); end
    bus_read(A_PER, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_reset_period got %h exp 0", d); end
    bus_read(A_DIR, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL async_reset_direct got %h exp ff", d); end
    checks++;
    if (led !== 8'hFF) begin errors++; $display("FAIL async_reset_idle_led got %h exp ff", led); end
  endtask

  initial begin
    int p;
    test_reset();
    test_direct();
    test_oneshot(3, 3, 1'b1);
    for (int i = 0; i < 3; i++) test_oneshot(int'($urandom_range(1, STEPS)), int'($urandom_range(0, 3)), 1'b0);
    test_hold_restart();
    p = int'($urandom_range(0, 2));
    test_loop_wrap(0);
    test_loop_wrap(p);
    for (int i = 0; i < 3; i++) test_abort(p, int'($urandom_range(1, STEPS - 1)));
    bus_write(A_CTRL, 32'(((STEPS - 1) << 4) | 1));
    repeat (3) @(negedge clk);
    test_abort(0, 1);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
